fft_butterfly: RTL and testbench

Radix-2 decimation-in-time FFT butterfly: takes complex inputs A and B and a complex twiddle W, and produces A + B·W and A − B·W. It is the arithmetic core of one FFT stage. A stage controller feeds operand pairs and twiddles every cycle, and the results return to the stage memory. The block is fully pipelined, accepts one butterfly per clock and has a fixed latency of 3 cycles.

---
 rtl/fft_pkg.sv | 39 +++
 rtl/fft_cmul.sv | 61 ++++++
 rtl/fft_butterfly.sv | 77 +++++++
 tb/tb_fft_butterfly.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default widths, complex payload type, and the
// rounding/saturation helpers used by every butterfly stage.
package fft_pkg;

  localparam int unsigned DEF_DATA_W  = 25;
  localparam int unsigned DEF_TW_FRAC = 23;
  // Working width for the helpers; wide enough for any 2*DATA_W+1 product up to DATA_W = 31.
  localparam int unsigned ACC_W       = 64;

  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] re;
    logic signed [DEF_DATA_W-1:0] im;
  } cplx_t;

  // Add one half LSB of the result, then drop frac bits (round-half-up).
  function automatic logic signed [ACC_W-1:0] round_half_up(
    input logic signed [ACC_W-1:0] x,
    input int unsigned             frac
  );
    logic signed [ACC_W-1:0] bias;
    bias = ACC_W'(1) << (frac - 1);
    return (x + bias) >>> frac;
  endfunction

  // Clamp to the range of a w-bit two's complement value.
  function automatic logic signed [ACC_W-1:0] saturate(
    input logic signed [ACC_W-1:0] x,
    input int unsigned             w
  );
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    hi = (ACC_W'(1) << (w - 1)) - ACC_W'(1);
    lo = ~hi;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/fft_cmul.sv
// Pipelined complex multiplier B*W: operand register, partial-product register,
// then combinational combine/round/saturate feeding the butterfly's output stage.
module fft_cmul
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TW_FRAC = DEF_TW_FRAC
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [2*DATA_W-1:0] b_i,
  input  logic [2*DATA_W-1:0] w_i,
  output logic [2*DATA_W-1:0] product_c
);

  localparam int unsigned PP_W   = 2 * DATA_W;
  localparam int unsigned PROD_W = 2 * DATA_W + 1;

  logic signed [DATA_W-1:0] br_q, bi_q, wr_q, wi_q;
  logic signed [PP_W-1:0]   rr_q, ii_q, ri_q, ir_q;
  logic signed [PROD_W-1:0] pr_raw, pi_raw;

  // Operand register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      br_q <= '0;
      bi_q <= '0;
      wr_q <= '0;
      wi_q <= '0;
    end else begin
      br_q <= b_i[2*DATA_W-1:DATA_W];
      bi_q <= b_i[DATA_W-1:0];
      wr_q <= w_i[2*DATA_W-1:DATA_W];
      wi_q <= w_i[DATA_W-1:0];
    end
  end

  // Partial-product register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_q <= '0;
      ii_q <= '0;
      ri_q <= '0;
      ir_q <= '0;
    end else begin
      rr_q <= PP_W'(br_q) * PP_W'(wr_q);
      ii_q <= PP_W'(bi_q) * PP_W'(wi_q);
      ri_q <= PP_W'(br_q) * PP_W'(wi_q);
      ir_q <= PP_W'(bi_q) * PP_W'(wr_q);
    end
  end

  // Combine, round and saturate back to DATA_W per component.
  always_comb begin
    pr_raw    = PROD_W'(rr_q) - PROD_W'(ii_q);
    pi_raw    = PROD_W'(ri_q) + PROD_W'(ir_q);
    product_c = {DATA_W'(saturate(round_half_up(ACC_W'(pr_raw), TW_FRAC), DATA_W)),
                 DATA_W'(saturate(round_half_up(ACC_W'(pi_raw), TW_FRAC), DATA_W))};
  end

endmodule

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: sum = A + B*W, diff = A - B*W, fixed 3-cycle latency,
// one butterfly per clock.
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TW_FRAC = DEF_TW_FRAC
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic [2*DATA_W-1:0]     signal_a_i,
  input  logic [2*DATA_W-1:0]     signal_b_i,
  input  logic [2*DATA_W-1:0]     twiddle_i,
  output logic [2*(DATA_W+1)-1:0] sum_o,
  output logic [2*(DATA_W+1)-1:0] diff_o,
  output logic                    valid_o
);

  localparam int unsigned OUT_W = DATA_W + 1;

  logic [2*DATA_W-1:0]      a1_q, a2_q;
  logic                     v1_q, v2_q;
  logic [2*DATA_W-1:0]      product_c;
  logic signed [DATA_W-1:0] a_re, a_im, p_re, p_im;
  logic signed [OUT_W-1:0]  sum_re, sum_im, diff_re, diff_im;

  fft_cmul #(
    .DATA_W  (DATA_W),
    .TW_FRAC (TW_FRAC)
  ) u_cmul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .b_i       (signal_b_i),
    .w_i       (twiddle_i),
    .product_c (product_c)
  );

  // A and valid ride two registers so they meet the product at the output stage.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a1_q <= '0;
      a2_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
    end else begin
      a1_q <= signal_a_i;
      a2_q <= a1_q;
      v1_q <= valid_i;
      v2_q <= v1_q;
    end
  end

  always_comb begin
    a_re    = a2_q[2*DATA_W-1:DATA_W];
    a_im    = a2_q[DATA_W-1:0];
    p_re    = product_c[2*DATA_W-1:DATA_W];
    p_im    = product_c[DATA_W-1:0];
    sum_re  = OUT_W'(a_re) + OUT_W'(p_re);
    sum_im  = OUT_W'(a_im) + OUT_W'(p_im);
    diff_re = OUT_W'(a_re) - OUT_W'(p_re);
    diff_im = OUT_W'(a_im) - OUT_W'(p_im);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sum_o   <= '0;
      diff_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      sum_o   <= {sum_re, sum_im};
      diff_o  <= {diff_re, diff_im};
      valid_o <= v2_q;
    end
  end

endmodule

// File: tb/tb_fft_butterfly.sv
// Bench for fft_butterfly: integer reference model on a 3-cycle delay line,
// checked every cycle, plus directed vectors with literal results.
module tb_fft_butterfly;
  import fft_pkg::*;

  localparam int unsigned DW = DEF_DATA_W;
  localparam int unsigned OW = DW + 1;
  localparam longint ONE  = 64'sd8388608;
  localparam longint HALF = 64'sd4194304;
  localparam longint SMAX = 64'sd16777215;
  localparam longint SMIN = -64'sd16777216;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            valid_i = 1'b0;
  logic [2*DW-1:0] signal_a_i = '0;
  logic [2*DW-1:0] signal_b_i = '0;
  logic [2*DW-1:0] twiddle_i = '0;
  logic [2*OW-1:0] sum_o;
  logic [2*OW-1:0] diff_o;
  logic            valid_o;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic   v;
    longint sr;
    longint si;
    longint dr;
    longint di;
  } exp_t;

  exp_t exp_q [3];

  fft_butterfly dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .signal_a_i (signal_a_i),
    .signal_b_i (signal_b_i),
    .twiddle_i  (twiddle_i),
    .sum_o      (sum_o),
    .diff_o     (diff_o),
    .valid_o    (valid_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic longint sat(input longint x);
    if (x > SMAX) return SMAX;
    if (x < SMIN) return SMIN;
    return x;
  endfunction

  function automatic longint scale(input longint x);
    return sat((x + HALF) >>> 23);
  endfunction

  function automatic exp_t model(input logic v, input longint ar, input longint ai,
                                 input longint br, input longint bi,
                                 input longint wr, input longint wi);
    exp_t   e;
    longint pr;
    longint pi;
    pr   = scale(br * wr - bi * wi);
    pi   = scale(br * wi + bi * wr);
    e.v  = v;
    e.sr = ar + pr;
    e.si = ai + pi;
    e.dr = ar - pr;
    e.di = ai - pi;
    return e;
  endfunction

  function automatic longint in_re(input logic [2*DW-1:0] x);
    logic signed [DW-1:0] t;
    t = x[2*DW-1:DW];
    return longint'(t);
  endfunction

  function automatic longint in_im(input logic [2*DW-1:0] x);
    logic signed [DW-1:0] t;
    t = x[DW-1:0];
    return longint'(t);
  endfunction

  function automatic longint out_re(input logic [2*OW-1:0] x);
    logic signed [OW-1:0] t;
    t = x[2*OW-1:OW];
    return longint'(t);
  endfunction

  function automatic longint out_im(input logic [2*OW-1:0] x);
    logic signed [OW-1:0] t;
    t = x[OW-1:0];
    return longint'(t);
  endfunction

  function automatic logic [2*DW-1:0] pack(input longint re, input longint im);
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    r = DW'(re);
    i = DW'(im);
    return {r, i};
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic check_outs(input string name, input longint sr, input longint si,
                            input longint dr, input longint di);
    check({name, ".sum_re"},  out_re(sum_o),  sr);
    check({name, ".sum_im"},  out_im(sum_o),  si);
    check({name, ".diff_re"}, out_re(diff_o), dr);
    check({name, ".diff_im"}, out_im(diff_o), di);
  endtask

  task automatic pin_model(input string name, input longint ar, input longint ai,
                           input longint br, input longint bi, input longint wr,
                           input longint wi, input longint sr, input longint si,
                           input longint dr, input longint di);
    exp_t e;
    e = model(1'b1, ar, ai, br, bi, wr, wi);
    check({name, ".sum_re"},  e.sr, sr);
    check({name, ".sum_im"},  e.si, si);
    check({name, ".diff_re"}, e.dr, dr);
    check({name, ".diff_im"}, e.di, di);
  endtask

  task automatic drive(input logic v, input longint ar, input longint ai, input longint br,
                       input longint bi, input longint wr, input longint wi);
    valid_i    = v;
    signal_a_i = pack(ar, ai);
    signal_b_i = pack(br, bi);
    twiddle_i  = pack(wr, wi);
  endtask

  task automatic drive_rand();
    logic [DW-1:0] r [6];
    for (int k = 0; k < 6; k++) r[k] = DW'($urandom);
    valid_i    = 1'b1;
    signal_a_i = {r[0], r[1]};
    signal_b_i = {r[2], r[3]};
    twiddle_i  = {r[4], r[5]};
  endtask

  // One valid operand, then the literal result three edges later.
  task automatic vec(input string name, input longint ar, input longint ai, input longint br,
                     input longint bi, input longint wr, input longint wi, input longint sr,
                     input longint si, input longint dr, input longint di);
    @(negedge clk_i); #2;
    drive(1'b1, ar, ai, br, bi, wr, wi);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check({name, ".valid"}, longint'(valid_o), 1);
    check_outs(name, sr, si, dr, di);
  endtask

  // Reference delay line: whatever was sampled three edges ago.
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < 3; i++) exp_q[i] <= '0;
    end else begin
      exp_q[2] <= exp_q[1];
      exp_q[1] <= exp_q[0];
      exp_q[0] <= model(valid_i, in_re(signal_a_i), in_im(signal_a_i), in_re(signal_b_i),
                        in_im(signal_b_i), in_re(twiddle_i), in_im(twiddle_i));
    end
  end

  always @(negedge clk_i) begin
    check("cyc.valid_o", longint'(valid_o), longint'(exp_q[2].v));
    check_outs("cyc", exp_q[2].sr, exp_q[2].si, exp_q[2].dr, exp_q[2].di);
  end

  initial begin
    pin_model("model_ident", 1, 1, 1, 0, ONE, 0, 2, 1, 0, 1);
    pin_model("model_sat", 0, 0, -64'sd16777216, 0, -ONE, 0, SMAX, 0, -SMAX, 0);
    pin_model("model_round", 0, 0, 1, 0, HALF, 0, 1, 0, -1, 0);
    pin_model("model_rot", 0, 0, 3, 0, 0, -ONE, 0, -3, 0, 3);

    #1 rst_i = 1'b0;
    drive(1'b1, 1, 1, 1, 0, ONE, 0);
    repeat (4) @(negedge clk_i);
    #1;
    check("rst_hold.valid", longint'(valid_o), 0);
    check_outs("rst_hold", 0, 0, 0, 0);

    #1;
    drive(1'b1, 0, 1, 0, 0, ONE, 0);
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_release.valid", longint'(valid_o), 1);
    check_outs("rst_release", 0, 1, 0, 1);

    vec("ident", 1, 1, 1, 0, ONE, 0, 2, 1, 0, 1);
    vec("neg_ext_re", -64'sd16777213, 1, 1, 0, ONE, 0,
        -64'sd16777212, 1, -64'sd16777214, 1);
    vec("neg_ext_im", 2, -64'sd16777214, 3, 0, ONE, 0,
        5, -64'sd16777214, -1, -64'sd16777214);
    vec("rotate", 0, 0, 3, 0, 0, -ONE, 0, -3, 0, 3);
    vec("round_up", 0, 0, 1, 0, HALF, 0, 1, 0, -1, 0);
    vec("round_neg_half", 5, -7, -1, 0, HALF, 0, 5, -7, 5, -7);
    vec("sat_pos", 0, 0, -64'sd16777216, 0, -ONE, 0, SMAX, 0, -SMAX, 0);
    vec("sat_neg", 0, 0, -64'sd16777216, -64'sd16777216, ONE, -ONE,
        -64'sd16777216, 0, 64'sd16777216, 0);
    vec("growth", SMAX, SMIN, SMAX, SMIN, ONE, 0,
        64'sd33554430, -64'sd33554432, 0, 0);

    // Back-to-back random stream, checked cycle by cycle against the model.
    @(negedge clk_i); #2;
    for (int n = 0; n < 10; n++) begin
      drive_rand();
      @(negedge clk_i); #2;
    end
    drive(1'b0, 0, 0, 0, 0, 0, 0);
    repeat (4) @(negedge clk_i);

    // Reset while operands are in flight.
    #2;
    drive_rand();
    @(negedge clk_i); #2;
    drive_rand();
    @(negedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    check("midrst.valid", longint'(valid_o), 0);
    check_outs("midrst", 0, 0, 0, 0);
    repeat (2) @(negedge clk_i);
    #2;
    drive(1'b0, 0, 0, 0, 0, ONE, 0);
    rst_i = 1'b1;
    repeat (6) @(negedge clk_i);
    #1;
    check("post_midrst.valid", longint'(valid_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
